// File: rtl/csc_syn_reader.sv
// Walks one CSC segment of the synaptic weight memory and streams its (column, weight) entries.
// Optional build macro CSC_ENTRY_COUNT_EN adds a saturating popped-entry counter output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a segment, start_ready high
// S_RUN   | issuing memory reads, throttled by output buffer space
// S_DRAIN | all reads issued, waiting for the last entry to be popped
module csc_syn_reader #(
  parameter int ADDR_W = 8,
  parameter int COL_W  = 5,
  parameter int WGT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] ptr_begin,
  input  logic [ADDR_W:0]   ptr_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COL_W-1:0]  mem_col_index,
  input  logic [WGT_W-1:0]  mem_syn_weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COL_W-1:0]  out_col_index,
  output logic [WGT_W-1:0]  out_syn_weight,
  output logic              out_last,
`ifdef CSC_ENTRY_COUNT_EN
  output logic [15:0]       entry_count,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE = 1;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W:0]    remaining;
  logic               inflight, inflight_last;
  logic [1:0]         occ;
  logic [2:0]         load;
  logic               issue, pop, push;

  logic [COL_W-1:0]   slot0_col, slot1_col;
  logic [WGT_W-1:0]   slot0_wgt, slot1_wgt;
  logic               slot0_last, slot1_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_valid && ptr_count != '0) state_nxt = S_RUN;
      S_RUN:   if (issue && remaining == REM_ONE) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && slot0_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue only when the buffer can absorb the read even if nothing drains next cycle.
  always_comb begin
    start_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    out_valid   = (occ != 2'd0);
    pop         = out_valid && out_ready;
    load        = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue       = (state == S_RUN) && (load < 3'd2);
  end

  assign push           = inflight;
  assign mem_addr       = ptr;
  assign out_col_index  = slot0_col;
  assign out_syn_weight = slot0_wgt;
  assign out_last       = slot0_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (state == S_IDLE && start_valid && ptr_count != '0) begin
        ptr       <= ptr_begin;
        remaining <= ptr_count;
      end else if (issue) begin
        ptr       <= ptr + PTR_ONE;
        remaining <= remaining - REM_ONE;
      end
      inflight      <= issue;
      inflight_last <= issue && (remaining == REM_ONE);
    end
  end

  // Two-slot shift FIFO, slot0 is the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      slot0_col  <= '0;
      slot0_wgt  <= '0;
      slot0_last <= 1'b0;
      slot1_col  <= '0;
      slot1_wgt  <= '0;
      slot1_last <= 1'b0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            slot0_col  <= mem_col_index;
            slot0_wgt  <= mem_syn_weight;
            slot0_last <= inflight_last;
          end else begin
            slot1_col  <= mem_col_index;
            slot1_wgt  <= mem_syn_weight;
            slot1_last <= inflight_last;
          end
        end
        2'b01: begin
          slot0_col  <= slot1_col;
          slot0_wgt  <= slot1_wgt;
          slot0_last <= slot1_last;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0_col  <= mem_col_index;
            slot0_wgt  <= mem_syn_weight;
            slot0_last <= inflight_last;
          end else begin
            slot0_col  <= slot1_col;
            slot0_wgt  <= slot1_wgt;
            slot0_last <= slot1_last;
            slot1_col  <= mem_col_index;
            slot1_wgt  <= mem_syn_weight;
            slot1_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CSC_ENTRY_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_count <= 16'd0;
    else if (pop && entry_count != 16'hFFFF) entry_count <= entry_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_csc_syn_reader.sv
// Bench for csc_syn_reader: queue-based segment model checked every cycle, plus directed scenarios.
module tb_csc_syn_reader;
  localparam int AW = 8;
  localparam int CW = 5;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] ptr_begin = '0;
  logic [AW:0]   ptr_count = '0;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_col_index = '0;
  logic [WW-1:0] mem_syn_weight = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_col_index;
  logic [WW-1:0] out_syn_weight;
  logic          out_last;
  logic          busy;
`ifdef CSC_ENTRY_COUNT_EN
  logic [15:0]   entry_count;
`endif

  csc_syn_reader #(.ADDR_W(AW), .COL_W(CW), .WGT_W(WW)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .ptr_begin(ptr_begin), .ptr_count(ptr_count),
    .mem_addr(mem_addr), .mem_col_index(mem_col_index), .mem_syn_weight(mem_syn_weight),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col_index(out_col_index), .out_syn_weight(out_syn_weight), .out_last(out_last),
`ifdef CSC_ENTRY_COUNT_EN
    .entry_count(entry_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] mcol [256];
  logic [WW-1:0] mwgt [256];
  always @(posedge clk) begin
    mem_col_index  <= mcol[mem_addr];
    mem_syn_weight <= mwgt[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct { int col; int wgt; bit last; } ent_t;
  ent_t exp_q[$];
  int   log_w[$];
  bit   log_l[$];
  bit   seg_active = 0;
  int   issued = 0, popped = 0, ecount = 0;
  int   prev_addr = 0;
  bit   prev_active = 0, prev_stall = 0;
  int   prev_col = 0, prev_wgt = 0;
  bit   prev_last = 0;

  // Model: a segment expands into a queue of entries when accepted while idle; DUT head must match.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_start_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_fields", {out_last, out_col_index, out_syn_weight}, 0);
      exp_q.delete();
      seg_active = 0; issued = 0; popped = 0; ecount = 0;
      prev_addr = 0; prev_active = 0; prev_stall = 0;
    end else begin
      bit accept;
      check("start_ready", start_ready, !seg_active);
      check("busy", busy, seg_active);
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          check("out_col", out_col_index, exp_q[0].col);
          check("out_wgt", out_syn_weight, exp_q[0].wgt);
          check("out_last", out_last, exp_q[0].last);
        end
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_col", out_col_index, prev_col);
        check("stall_wgt", out_syn_weight, prev_wgt);
        check("stall_last", out_last, prev_last);
      end
      if (prev_active && mem_addr != prev_addr) issued++;
      check("issue_ahead_bound", (issued - popped) <= 2, 1);
`ifdef CSC_ENTRY_COUNT_EN
      check("entry_count", entry_count, ecount);
`endif
      prev_stall  = out_valid && !out_ready;
      prev_col    = out_col_index;
      prev_wgt    = out_syn_weight;
      prev_last   = out_last;
      prev_addr   = mem_addr;
      prev_active = seg_active;
      accept = start_valid && !seg_active && (ptr_count != 0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        ent_t e;
        e = exp_q.pop_front();
        log_w.push_back(e.wgt);
        log_l.push_back(e.last);
        popped++;
        if (ecount < 65535) ecount++;
        if (e.last) seg_active = 0;
      end
      if (accept) begin
        for (int i = 0; i < ptr_count; i++) begin
          ent_t e;
          int a;
          a = (ptr_begin + i) % 256;
          e.col = mcol[a]; e.wgt = mwgt[a]; e.last = (i == ptr_count - 1);
          exp_q.push_back(e);
        end
        seg_active = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_seg(input int b, input int c);
    start_valid = 1; ptr_begin = AW'(b); ptr_count = (AW+1)'(c);
    cyc();
    start_valid = 0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || seg_active) && n < bound) begin cyc(); n++; end
    check("drain_timeout", n < bound, 1);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w[$];
    bit pat [4];
    for (int k = 0; k < 256; k++) begin mcol[k] = CW'(k % 32); mwgt[k] = WW'(k); end
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_addr", mem_addr, 0);
    check("reset_start_ready", start_ready, 1);
    rst = 0;
    cyc(); cyc();

    // begin=10 count=4: entries in cycles 3..6, start_ready back by cycle 8
    out_ready = 1;
    start_seg(10, 4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("lat_valid", out_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        check("lat_wgt", out_syn_weight, c + 7);
        check("lat_col", out_col_index, (c + 7) % 32);
        check("lat_last", out_last, c == 6);
      end
      if (c == 8) check("lat_start_ready_c8", start_ready, 1);
      @(posedge clk); #1;
    end

    // address wrap
    log_w.delete(); log_l.delete();
    start_seg(254, 4);
    wait_done(40);
    exp_w = '{254, 255, 0, 1};
    check("wrap_len", log_w.size(), 4);
    for (int i = 0; i < 4 && i < log_w.size(); i++) begin
      check("wrap_wgt", log_w[i], exp_w[i]);
      check("wrap_last", log_l[i], i == 3);
    end

    // zero-length segment
    start_seg(33, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("zero_valid", out_valid, 0);
      check("zero_ready", start_ready, 1);
      check("zero_busy", busy, 0);
      @(posedge clk); #1;
    end

    // out_ready 1,0,0,1 repeating
    log_w.delete(); log_l.delete();
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    for (int k = 0; k < 100 && (k < 2 || seg_active); k++) begin
      out_ready = pat[k % 4];
      start_valid = (k == 0); ptr_begin = 0; ptr_count = 8;
      cyc();
    end
    start_valid = 0; out_ready = 1;
    cyc();
    check("toggle_len", log_w.size(), 8);
    for (int i = 0; i < 8 && i < log_w.size(); i++) begin
      check("toggle_wgt", log_w[i], i);
      check("toggle_last", log_l[i], i == 7);
    end

    // reset in the middle of a full-memory segment
    start_seg(0, 256);
    for (int c = 1; c < 50; c++) begin out_ready = 1'($urandom % 2); cyc(); end
    #3 rst = 1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_ready", start_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_fields", {out_last, out_col_index, out_syn_weight}, 0);
    cyc(); cyc();
    rst = 0; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("postrst_valid", out_valid, 0);
      @(posedge clk); #1;
    end

`ifdef CSC_ENTRY_COUNT_EN
    start_seg(0, 3);
    wait_done(40);
    start_seg(5, 5);
    wait_done(40);
    check("entry_count_8", entry_count, 8);
`endif

    // randomized segments and back-pressure
    for (int k = 0; k < 256; k++) begin mcol[k] = CW'($urandom); mwgt[k] = WW'($urandom); end
    for (int c = 0; c < 3000; c++) begin
      int bias, r;
      bias = 20 + ((c / 250) % 4) * 25;
      out_ready = ($urandom % 100) < bias;
      start_valid = ($urandom % 6) == 0;
      ptr_begin = AW'($urandom);
      r = $urandom % 16;
      if (r == 0) ptr_count = 0;
      else if (r == 1) ptr_count = (AW+1)'($urandom_range(100, 256));
      else ptr_count = (AW+1)'($urandom_range(1, 12));
      cyc();
    end
    start_valid = 0; out_ready = 1;
    wait_done(800);
    check("final_idle", start_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
